// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss BCD countdown with presettable start value.
//
// Parameters:
//   TICK_DIV   - clk cycles per one-second tick
//   PRESET_MIN - preset minutes loaded at reset (0-59)
//   PRESET_SEC - preset seconds loaded at reset (0-59)
//
// Ports:
//   clk                - system clock
//   rst_n              - asynchronous active-low reset
//   start_i            - pulse: start from IDLE, resume from PAUSE, acknowledge DONE
//   pause_i            - pulse: pause while running
//   clear_i            - pulse: abort to IDLE, display restored to preset
//   set_min_i          - pulse: preset minutes +1 (IDLE only, 59 wraps to 00)
//   set_sec_i          - pulse: preset seconds +1 (IDLE only, 59 wraps to 00)
//   min_tens .. sec_ones - registered BCD display digits
//   running            - high while in RUN
//   done               - one-cycle pulse at expiry
//
// Build option:
//   COUNTDOWN_AUTO_RELOAD_EN - when defined, expiry reloads the preset and keeps
//   running instead of entering DONE.

module countdown_timer #(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned PRESET_MIN = 1,
    parameter int unsigned PRESET_SEC = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       clear_i,
    input  logic       set_min_i,
    input  logic       set_sec_i,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done
);

    localparam int unsigned   PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    // Packed as {min_tens, min_ones, sec_tens, sec_ones}.
    localparam logic [15:0] RESET_PRESET = {4'(PRESET_MIN / 10), 4'(PRESET_MIN % 10),
                                            4'(PRESET_SEC / 10), 4'(PRESET_SEC % 10)};

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e         state_q, state_d;
    logic [15:0]    preset_q, preset_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic           running_q, running_d;
    logic           done_q, done_d;

    logic           tick;
    logic           expire;
    logic [15:0]    dec_val;

    // Two-digit BCD increment with 59 -> 00 wrap.
    function automatic logic [7:0] inc59(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // mm:ss BCD decrement with borrow; never called on 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = v;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign tick    = (state_q == StRun) && (presc_q == TERM);
    assign dec_val = bcd_dec(cnt_q);
    assign expire  = tick && (dec_val == 16'h0000);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            preset_q  <= RESET_PRESET;
            cnt_q     <= RESET_PRESET;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            preset_q  <= preset_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        cnt_d    = cnt_q;
        presc_d  = presc_q;
        case (state_q)
            StIdle: begin
                if (set_min_i) preset_d[15:8] = inc59(preset_q[15:8]);
                if (set_sec_i) preset_d[7:0]  = inc59(preset_q[7:0]);
                cnt_d   = preset_d;
                presc_d = '0;
                if (start_i && (preset_q != 16'h0000)) state_d = StRun;
            end
            StRun: begin
                if (clear_i) begin
                    state_d = StIdle;
                    cnt_d   = preset_q;
                    presc_d = '0;
                end else begin
                    presc_d = tick ? '0 : presc_q + ONE;
                    if (tick) cnt_d = dec_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (expire) cnt_d = preset_q;
                    if (pause_i) state_d = StPause;
`else
                    // Expiry wins over a coincident pause.
                    if (expire) begin
                        state_d = StDone;
                    end else if (pause_i) begin
                        state_d = StPause;
                    end
`endif
                end
            end
            StPause: begin
                if (clear_i) begin
                    state_d = StIdle;
                    cnt_d   = preset_q;
                    presc_d = '0;
                end else if (!pause_i && start_i) begin
                    // Prescaler keeps its held value so no partial second is lost.
                    state_d = StRun;
                end
            end
            StDone: begin
                if (clear_i || start_i) begin
                    state_d = StIdle;
                    cnt_d   = preset_q;
                    presc_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = preset_q;
                presc_d = '0;
            end
        endcase
    end

    // Output decode (registered in the state register block)
    always_comb begin
        running_d = (state_d == StRun);
        done_d    = expire && !clear_i;
    end

    assign {min_tens, min_ones, sec_tens, sec_ones} = cnt_q;
    assign running = running_q;
    assign done    = done_q;

endmodule
